jtag_gpr_access: RTL and testbench
==================================

// Module: jtag_gpr_access
// PURPOSE
//  Debug-side initiator for the register file's JTAG GPR port (we/addr/wdata out, rdata in).
//  Accepts one GPR read or write command per valid/ready handshake from the debug transport.
//  Halts the core, performs the access, verifies writes by read-back and returns a response.
//  Sits between the DMI/debug module and regs_file; one instance per core.
// PARAMETERS
//  HALT_TIMEOUT  64  cycles to wait for halted_i after halt_req_o before aborting
//  MAX_RETRY     3   write re-issues after a read-back mismatch (0 = no retry)
// PORTS
//  clk             in   1   single clock; all logic on posedge
//  rst             in   1   synchronous, active-high reset
//  cmd_valid_i     in   1   command present
//  cmd_ready_o     out  1   command accepted this cycle (valid&ready)
//  cmd_write_i     in   1   1 = write GPR, 0 = read GPR
//  cmd_addr_i      in   5   GPR index (REG_ADDR_WIDTH)
//  cmd_data_i      in   32  write data (CPU_WIDTH)
//  rsp_valid_o     out  1   response present; held until rsp_ready_i
//  rsp_ready_i     in   1   response consumed
//  rsp_data_o      out  32  read data / final read-back value for writes
//  rsp_status_o    out  2   00 OK, 01 VERIFY_FAIL, 10 HALT_TIMEOUT, 11 reserved
//  halt_req_o      out  1   request core halt
//  halted_i        in   1   core is halted (no GPR writeback in flight)
//  jtag_we_o       out  1   regfile JTAG write strobe
//  jtag_addr_o     out  5   regfile JTAG address
//  jtag_data_o     out  32  regfile JTAG write data
//  jtag_data_i     in   32  regfile JTAG read data (combinational from jtag_addr_o; 0 for x0)
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_status_o=00,
//   halt_req_o=0, jtag_we_o=0, jtag_addr_o=0, jtag_data_o=0, retry/timeout counters 0.
//  FSM: IDLE -> HALT -> ACCESS -> [VERIFY] -> RESP -> IDLE.
//  IDLE: cmd_ready_o=1; on valid&ready latch write/addr/data into cmd regs, drive
//   jtag_addr_o/jtag_data_o from them, assert halt_req_o, go HALT. cmd_ready_o=0 outside IDLE.
//  HALT: count cycles; halted_i=1 -> ACCESS. Count reaches HALT_TIMEOUT with halted_i=0 ->
//   RESP with status 10, rsp_data_o=0, no jtag_we_o issued.
//  ACCESS read: sample jtag_data_i into rsp_data_o, status 00 -> RESP (1 cycle).
//  ACCESS write: jtag_we_o=1 for exactly this cycle -> VERIFY.
//  VERIFY: compare jtag_data_i with cmd data. Match -> status 00. Mismatch and
//   retry<MAX_RETRY -> retry+1, back to ACCESS. Mismatch at limit -> status 01.
//   rsp_data_o = sampled jtag_data_i in all cases.
//  Address 0: write skips jtag_we_o and VERIFY, returns status 00, rsp_data_o=0;
//   read returns 0 (regfile hard-wires x0). Halt still requested (uniform latency).
//  halted_i dropping after HALT: no abort; a lost write shows up as mismatch -> retry.
//  RESP: rsp_valid_o=1, outputs stable until rsp_ready_i; on handshake deassert
//   halt_req_o, clear counters, go IDLE (cmd_ready_o=1 next cycle, no back-to-back).
//  Latency valid&ready->rsp_valid: read = 2 + halt wait; write = 3 + halt wait + 2/retry.
//  rst mid-operation: return to reset values next edge; in-flight command dropped,
//   no partial jtag_we_o after rst sampled high.
//  jtag_addr_o/jtag_data_o hold last command values between commands (no glitch to 0).
// STRUCTURE
//  Shared defines: REG_ADDR_WIDTH, CPU_WIDTH, RSP_OK/RSP_VERIFY_FAIL/RSP_HALT_TO codes,
//   FSM state encodings. Single module; no sub-module needed (counters inline).
// TESTING
//  1 write x5=0xDEADBEEF, halted_i 2 cycles after req -> one jtag_we_o pulse, status 00, data 0xDEADBEEF.
//  2 read x7 holding 0x12345678 -> rsp_data_o=0x12345678, status 00, no jtag_we_o.
//  3 halted_i never set -> rsp after 64 cycles, status 10, zero jtag_we_o pulses.
//  4 write x3=0xA5A5A5A5, model drops first write (core write same cycle) -> 2 pulses, status 00.
//  5 model drops all writes, MAX_RETRY=3 -> 4 pulses, status 01, halt_req_o low after rsp.
//  6 write x0=0xFFFFFFFF -> no pulse, status 00, data 0; rst during HALT -> all reset values.

Source files
------------

// File: rtl/jtag_gpr_access_pkg.sv
// Shared widths, response codes and FSM encodings for the JTAG GPR access initiator.
package jtag_gpr_access_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int CPU_WIDTH      = 32;

  typedef enum logic [1:0] {
    RSP_OK          = 2'b00,
    RSP_VERIFY_FAIL = 2'b01,
    RSP_HALT_TO     = 2'b10,
    RSP_RSVD        = 2'b11
  } rsp_status_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HALT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_VERIFY = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // x0 is hard-wired to zero in the register file, so it is never written.
  function automatic logic is_x0(input logic [REG_ADDR_WIDTH-1:0] addr);
    return (addr == {REG_ADDR_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/jtag_gpr_access.sv
// Debug-side initiator for the regfile JTAG GPR port: halts the core, performs one
// read or write per command, verifies writes by read-back (with retries) and responds.
module jtag_gpr_access
  import jtag_gpr_access_pkg::*;
#(
  parameter int HALT_TIMEOUT = 64,
  parameter int MAX_RETRY    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [CPU_WIDTH-1:0]      cmd_data_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [CPU_WIDTH-1:0]      rsp_data_o,
  output logic [1:0]                rsp_status_o,
  output logic                      halt_req_o,
  input  logic                      halted_i,
  output logic                      jtag_we_o,
  output logic [REG_ADDR_WIDTH-1:0] jtag_addr_o,
  output logic [CPU_WIDTH-1:0]      jtag_data_o,
  input  logic [CPU_WIDTH-1:0]      jtag_data_i
);

  localparam int HALT_CNT_W = $clog2(HALT_TIMEOUT + 1);
  localparam int RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [HALT_CNT_W-1:0] HALT_LAST = HALT_CNT_W'(HALT_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0]    RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_e                state_r;
  logic                  cmd_write_r;
  logic [HALT_CNT_W-1:0] halt_cnt_r;
  logic [RETRY_W-1:0]    retry_cnt_r;

  // Command FSM; jtag_addr_o/jtag_data_o double as the latched command address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cmd_write_r  <= 1'b0;
      halt_cnt_r   <= {HALT_CNT_W{1'b0}};
      retry_cnt_r  <= {RETRY_W{1'b0}};
      cmd_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= {CPU_WIDTH{1'b0}};
      rsp_status_o <= RSP_OK;
      halt_req_o   <= 1'b0;
      jtag_we_o    <= 1'b0;
      jtag_addr_o  <= {REG_ADDR_WIDTH{1'b0}};
      jtag_data_o  <= {CPU_WIDTH{1'b0}};
    end else begin
      jtag_we_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_write_r <= cmd_write_i;
            jtag_addr_o <= cmd_addr_i;
            jtag_data_o <= cmd_data_i;
            halt_req_o  <= 1'b1;
            cmd_ready_o <= 1'b0;
            halt_cnt_r  <= {HALT_CNT_W{1'b0}};
            state_r     <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (halted_i) begin
            jtag_we_o <= cmd_write_r && !is_x0(jtag_addr_o);
            state_r   <= ST_ACCESS;
          end else if (halt_cnt_r == HALT_LAST) begin
            rsp_data_o   <= {CPU_WIDTH{1'b0}};
            rsp_status_o <= RSP_HALT_TO;
            rsp_valid_o  <= 1'b1;
            state_r      <= ST_RESP;
          end else begin
            halt_cnt_r <= halt_cnt_r + 1'b1;
          end
        end
        ST_ACCESS: begin
          if (is_x0(jtag_addr_o)) begin
            rsp_data_o   <= {CPU_WIDTH{1'b0}};
            rsp_status_o <= RSP_OK;
            rsp_valid_o  <= 1'b1;
            state_r      <= ST_RESP;
          end else if (!cmd_write_r) begin
            rsp_data_o   <= jtag_data_i;
            rsp_status_o <= RSP_OK;
            rsp_valid_o  <= 1'b1;
            state_r      <= ST_RESP;
          end else begin
            state_r <= ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          // A write lost to a concurrent core writeback reads back wrong and is re-issued.
          if (jtag_data_i == jtag_data_o) begin
            rsp_data_o   <= jtag_data_i;
            rsp_status_o <= RSP_OK;
            rsp_valid_o  <= 1'b1;
            state_r      <= ST_RESP;
          end else if (retry_cnt_r < RETRY_MAX) begin
            retry_cnt_r <= retry_cnt_r + 1'b1;
            jtag_we_o   <= 1'b1;
            state_r     <= ST_ACCESS;
          end else begin
            rsp_data_o   <= jtag_data_i;
            rsp_status_o <= RSP_VERIFY_FAIL;
            rsp_valid_o  <= 1'b1;
            state_r      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            halt_req_o  <= 1'b0;
            halt_cnt_r  <= {HALT_CNT_W{1'b0}};
            retry_cnt_r <= {RETRY_W{1'b0}};
            cmd_ready_o <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_o <= 1'b0;
          halt_req_o  <= 1'b0;
          cmd_ready_o <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_gpr_access.sv
// Directed self-checking bench for jtag_gpr_access with a small regfile/halt model.
module tb_jtag_gpr_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [4:0]  cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [1:0]  rsp_status_o;
  logic        halt_req_o, halted_i, jtag_we_o;
  logic [4:0]  jtag_addr_o;
  logic [31:0] jtag_data_o, jtag_data_i;

  int n_cmp = 0;
  int n_err = 0;

  // Model knobs, driven from the stimulus block.
  logic halt_en;
  int   halt_delay;
  logic drop_all;
  int   drop_idx;

  // Model state, owned by the model processes.
  logic [31:0] regs [32];
  int          halt_cnt;
  int          pulses;

  jtag_gpr_access dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o),
    .halt_req_o(halt_req_o), .halted_i(halted_i),
    .jtag_we_o(jtag_we_o), .jtag_addr_o(jtag_addr_o),
    .jtag_data_o(jtag_data_o), .jtag_data_i(jtag_data_i)
  );

  always #5 clk = ~clk;

  assign jtag_data_i = (jtag_addr_o == 5'd0) ? 32'd0 : regs[jtag_addr_o];
  assign halted_i    = halt_en && halt_req_o && (halt_cnt >= halt_delay);

  // Core halt model: halted_i rises halt_delay cycles after halt_req_o.
  always @(posedge clk) begin
    if (rst || !halt_req_o) halt_cnt <= 0;
    else                    halt_cnt <= halt_cnt + 1;
  end

  // Regfile model: counts write strobes and can drop selected writes.
  always @(posedge clk) begin
    if (rst) begin
      pulses <= 0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (jtag_we_o) begin
      pulses <= pulses + 1;
      if (!(drop_all || pulses == drop_idx) && jtag_addr_o != 5'd0)
        regs[jtag_addr_o] <= jtag_data_o;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".cmd_ready"}, {31'd0, cmd_ready_o}, 32'd1);
    check_eq({tag, ".rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
    check_eq({tag, ".rsp_data"},  rsp_data_o, 32'd0);
    check_eq({tag, ".rsp_status"}, {30'd0, rsp_status_o}, 32'd0);
    check_eq({tag, ".halt_req"},  {31'd0, halt_req_o}, 32'd0);
    check_eq({tag, ".jtag_we"},   {31'd0, jtag_we_o}, 32'd0);
    check_eq({tag, ".jtag_addr"}, {27'd0, jtag_addr_o}, 32'd0);
    check_eq({tag, ".jtag_data"}, jtag_data_o, 32'd0);
  endtask

  // Issue one command, measure latency, check response hold and release.
  task automatic run_cmd(input string tag, input logic w, input logic [4:0] a,
                         input logic [31:0] d, output logic [31:0] rdata,
                         output logic [1:0] rstat, output int lat, output int npulse);
    int wait_n;
    int p0;
    wait_n = 0;
    @(negedge clk);
    while (!cmd_ready_o && wait_n < 200) begin @(negedge clk); wait_n++; end
    check_eq({tag, ".ready_wait"}, {31'd0, cmd_ready_o}, 32'd1);
    p0 = pulses;
    cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a; cmd_data_i = d;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    lat = 0;
    while (!rsp_valid_o && lat < 200) begin @(negedge clk); lat++; end
    rdata = rsp_data_o;
    rstat = rsp_status_o;
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, ".rsp_hold"}, {31'd0, rsp_valid_o}, 32'd1);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check_eq({tag, ".rsp_drop"}, {31'd0, rsp_valid_o}, 32'd0);
    check_eq({tag, ".halt_rel"}, {31'd0, halt_req_o}, 32'd0);
    npulse = pulses - p0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  st;
    int          lat;
    int          np;

    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 5'd0; cmd_data_i = 32'd0;
    rsp_ready_i = 1'b0;
    halt_en = 1'b1; halt_delay = 0; drop_all = 1'b0; drop_idx = -1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // 1: write x5, halt acknowledged 2 cycles late
    halt_delay = 2;
    run_cmd("wr_x5", 1'b1, 5'd5, 32'hDEADBEEF, rd, st, lat, np);
    check_eq("wr_x5.status", {30'd0, st}, 32'd0);
    check_eq("wr_x5.data", rd, 32'hDEADBEEF);
    check_eq("wr_x5.pulses", np, 32'd1);
    check_eq("wr_x5.latency", lat, 32'd5);
    halt_delay = 0;

    // Preload x7, then 2: read it back
    run_cmd("wr_x7", 1'b1, 5'd7, 32'h12345678, rd, st, lat, np);
    check_eq("wr_x7.latency", lat, 32'd3);
    run_cmd("rd_x7", 1'b0, 5'd7, 32'h0, rd, st, lat, np);
    check_eq("rd_x7.data", rd, 32'h12345678);
    check_eq("rd_x7.status", {30'd0, st}, 32'd0);
    check_eq("rd_x7.pulses", np, 32'd0);
    check_eq("rd_x7.latency", lat, 32'd2);
    check_eq("rd_x7.addr_hold", {27'd0, jtag_addr_o}, 32'd7);

    // 3: core never halts
    halt_en = 1'b0;
    run_cmd("halt_to", 1'b1, 5'd4, 32'h0BADF00D, rd, st, lat, np);
    check_eq("halt_to.status", {30'd0, st}, 32'd2);
    check_eq("halt_to.data", rd, 32'd0);
    check_eq("halt_to.pulses", np, 32'd0);
    check_eq("halt_to.latency", lat, 32'd64);
    halt_en = 1'b1;

    // 4: first write lost, one retry
    drop_idx = pulses;
    run_cmd("retry1", 1'b1, 5'd3, 32'hA5A5A5A5, rd, st, lat, np);
    check_eq("retry1.pulses", np, 32'd2);
    check_eq("retry1.status", {30'd0, st}, 32'd0);
    check_eq("retry1.data", rd, 32'hA5A5A5A5);
    check_eq("retry1.latency", lat, 32'd5);
    drop_idx = -1;

    // 5: every write lost, retries exhausted
    run_cmd("wr_x9", 1'b1, 5'd9, 32'h11111111, rd, st, lat, np);
    drop_all = 1'b1;
    run_cmd("vfail", 1'b1, 5'd9, 32'h22222222, rd, st, lat, np);
    check_eq("vfail.pulses", np, 32'd4);
    check_eq("vfail.status", {30'd0, st}, 32'd1);
    check_eq("vfail.data", rd, 32'h11111111);
    check_eq("vfail.latency", lat, 32'd9);
    drop_all = 1'b0;

    // 6: write to x0 is suppressed
    run_cmd("wr_x0", 1'b1, 5'd0, 32'hFFFFFFFF, rd, st, lat, np);
    check_eq("wr_x0.pulses", np, 32'd0);
    check_eq("wr_x0.status", {30'd0, st}, 32'd0);
    check_eq("wr_x0.data", rd, 32'd0);
    check_eq("wr_x0.latency", lat, 32'd2);

    // Reset while waiting for halt
    halt_en = 1'b0;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 5'd12; cmd_data_i = 32'hCAFEF00D;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_rst.halt_req_pre", {31'd0, halt_req_o}, 32'd1);
    check_eq("mid_rst.jtag_data_pre", jtag_data_o, 32'hCAFEF00D);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rst");
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
